bitidx_enum: RTL
================

// Module: bitidx_enum
//
// PURPOSE
//  Expander for the microphone hit-vector: the popcount adder tree compresses an
//  NDATA-bit hit vector into a count; this block walks the same vector and emits,
//  one per handshake, the index of every set bit in ascending order.
//  It then pulses done with the total count.
//  Sits between per-channel threshold detectors and the localisation sequencer.
//  The sequencer consumes channel indices to fetch per-microphone timestamps.
//
// PARAMETERS
//  NDATA      128             width of hit vector (power of two, >=4)
//  NDATA_LOG  $clog2(NDATA)   localparam; index width
//
// PORTS
//  clk        in   1            system clock, rising edge
//  rst_n      in   1            reset
//  start      in   1            capture din and begin scan; honoured in IDLE only
//  din        in   NDATA        hit vector, sampled on the clk edge where start=1 in IDLE
//  busy       out  1            high in SCAN and DONE
//  idx        out  NDATA_LOG    index of lowest remaining set bit
//  idx_valid  out  1            idx is valid
//  idx_ready  in   1            consumer accepts idx
//  done       out  1            one-cycle pulse, scan complete
//  count      out  NDATA_LOG+1  indices emitted; final value valid with done, held until next start
//
// BEHAVIOUR
//  - One clock, clk. Reset rst_n is asynchronous, active-low.
//  - Reset: state=IDLE, mask=0, count=0, idx=0, idx_valid=0, done=0, busy=0.
//  - Reset acts immediately, mid-scan included. The scan is abandoned and no done pulse is issued.
//  - The mask register holds the remaining set bits.
//  - Definitions: idx = index of the lowest set bit of mask, or 0 when mask==0;
//    idx_valid = (state==SCAN).
//  - IDLE:
//    - start=1 and din!=0: mask<=din, count<=0, go to SCAN.
//    - start=1 and din==0: count<=0, go to DONE.
//    - start=0: stay in IDLE.
//  - SCAN (mask!=0 invariant):
//    - Handshake = idx_valid & idx_ready.
//    - On a handshake, clear mask[idx] and increment count.
//    - If that handshake clears the last bit, go to DONE.
//    - With no handshake, idx and idx_valid stay stable; no bit is dropped.
//  - DONE: done=1 for exactly one cycle, then go to IDLE.
//  - start is ignored in SCAN and DONE. The scan in progress is not disturbed and din is not sampled.
//  - Latency: the first idx_valid appears in the cycle after the start edge.
//    With idx_ready held high, throughput is one index per cycle.
//    done rises in the cycle after the final handshake, or the cycle after start when din==0.
//  - Width rules:
//    - count is NDATA_LOG+1 bits, so an all-ones vector yields count=NDATA with no wrap.
//    - Indices never exceed NDATA-1.
//  - Invariant: count at done equals popcount(din captured at start).
//
// STRUCTURE
//  - Shared package edc_pkg: NDATA default; state enum {IDLE, SCAN, DONE}.
//  - One sub-module, lsb_prio_enc (parameter NDATA):
//    - Combinational lowest-set-bit encoder: in [NDATA-1:0] -> idx [NDATA_LOG-1:0], any.
//    - Built as a log2 tree of 2:1 merge stages.
//  - Top level holds the FSM, the mask, the count and the handshake logic.
//
// TESTING
//  1. din=0, start -> done=1 in cycle+1 with count=0; idx_valid never asserts; busy low after.
//  2. din bits {0,127}, idx_ready=1 -> idx=0 then idx=127 on consecutive cycles;
//     done in the next cycle, count=2.
//  3. din all-ones, idx_ready=1 -> 128 back-to-back indices 0..127; done, count=128 (8'h80).
//  4. din=128'hA (bits 1,3), idx_ready low for 5 cycles -> idx=1 held stable with idx_valid=1;
//     then ready toggling -> 1 then 3, count=2, no duplicates.
//  5. Two starts and a reset:
//     - A second start with a different din mid-scan -> ignored; output matches the first vector.
//     - rst_n low mid-scan -> all outputs 0 at once, no done.
//     - A fresh start after reset -> correct sequence.
//  6. 1000 random din values with random idx_ready -> index stream and count match the reference model;
//     the done pulse is always exactly 1 cycle wide.

Source files
------------

// File: rtl/edc_pkg.sv
// edc_pkg: shared hit-vector width and scan FSM states
package edc_pkg;
  localparam int NDATA_DEF = 128;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/lsb_prio_enc.sv
// lsb_prio_enc: lowest-set-bit encoder built as a recursive tree of 2:1 merges
module lsb_prio_enc import edc_pkg::*; #(
  parameter int NDATA = NDATA_DEF,
  localparam int NDATA_LOG = $clog2(NDATA)
) (
  input  logic [NDATA-1:0]     in,
  output logic [NDATA_LOG-1:0] idx,
  output logic                 any
);
  if (NDATA == 2) begin : g_leaf
    assign any = |in;
    assign idx = ~in[0];
  end else begin : g_split
    logic [NDATA_LOG-2:0] lo_idx, hi_idx;
    logic                 lo_any, hi_any;
    lsb_prio_enc #(.NDATA(NDATA/2)) u_lo (.in(in[NDATA/2-1:0]), .idx(lo_idx), .any(lo_any));
    lsb_prio_enc #(.NDATA(NDATA/2)) u_hi (.in(in[NDATA-1:NDATA/2]), .idx(hi_idx), .any(hi_any));
    // the lower half wins whenever it has any set bit
    assign any = lo_any | hi_any;
    assign idx = lo_any ? {1'b0, lo_idx} : {1'b1, hi_idx};
  end
endmodule

// File: rtl/bitidx_enum.sv
// bitidx_enum: emits the index of every set bit of a hit vector, lowest first, then pulses done with the count
module bitidx_enum import edc_pkg::*; #(
  parameter int NDATA = NDATA_DEF,
  localparam int NDATA_LOG = $clog2(NDATA)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NDATA-1:0]     din,
  output logic                 busy,
  output logic [NDATA_LOG-1:0] idx,
  output logic                 idx_valid,
  input  logic                 idx_ready,
  output logic                 done,
  output logic [NDATA_LOG:0]   count
);
  state_t               state, nxt;
  logic [NDATA-1:0]     mask, onehot;
  logic [NDATA_LOG-1:0] enc_idx;
  logic                 any, hs;
  lsb_prio_enc #(.NDATA(NDATA)) u_enc (.in(mask), .idx(enc_idx), .any(any));
  assign idx       = any ? enc_idx : '0;
  assign onehot    = {{(NDATA-1){1'b0}}, 1'b1} << enc_idx;
  assign idx_valid = state == SCAN;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign hs        = idx_valid & idx_ready;
  always_comb begin
    nxt = state == IDLE ? (start ? (|din ? SCAN : DONE) : IDLE) :
          state == SCAN ? ((hs && mask == onehot) ? DONE : SCAN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mask  <= '0;
      count <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        mask  <= din;
        count <= '0;
      end else if (hs) begin
        mask  <= mask & ~onehot;
        count <= count + 1'b1;
      end
    end
  end
endmodule
